// File: rtl/median3_window_feeder.sv
// median3_window_feeder
// Feeds a sliding 3-sample window to an external combinational median block
// (middle_finder) and registers its MIDDLE result behind a valid/ready output.
// A is the newest sample, C the oldest. One median per cycle when unstalled.

module median3_window_feeder #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Flush,
    input  logic [WIDTH-1:0] Din,
    input  logic             Din_valid,
    output logic             Din_ready,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] C,
    input  logic [WIDTH-1:0] Middle_in,
    output logic [WIDTH-1:0] Mid_out,
    output logic             Mid_valid,
    input  logic             Mid_ready,
    output logic [CNT_W-1:0] Res_count
);

    typedef enum logic [1:0] {
        FILL0,
        FILL1,
        FILL2,
        RUN
    } state_t;

    state_t state;
    state_t state_next;

    logic pend;
    logic pend_next;
    logic acc;
    logic slot;
    logic capture;
    logic window_full;

    // A window is waiting for the output register; the register is free when
    // empty or being drained this cycle. Input is only blocked when both a
    // window is pending and the output register cannot take it.
    assign slot        = ~Mid_valid | Mid_ready;
    assign Din_ready   = ~pend | slot;
    assign acc         = Din_valid & Din_ready;
    assign capture     = pend & slot;
    assign window_full = (state == FILL2) || (state == RUN);

    // Fill-state register
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state <= FILL0;
        end else begin
            state <= state_next;
        end
    end

    // Next fill state and next pending flag; flush discards any accept
    always_comb begin
        state_next = state;
        pend_next  = pend;
        if (Flush) begin
            state_next = FILL0;
            pend_next  = 1'b0;
        end else begin
            if (acc) begin
                unique case (state)
                    FILL0:   state_next = FILL1;
                    FILL1:   state_next = FILL2;
                    FILL2:   state_next = RUN;
                    default: state_next = RUN;
                endcase
            end
            if (acc && window_full) begin
                pend_next = 1'b1;
            end else if (capture) begin
                pend_next = 1'b0;
            end
        end
    end

    // Pending flag register
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            pend <= 1'b0;
        end else begin
            pend <= pend_next;
        end
    end

    // Sliding window: shift newest sample into A on each accept
    always_ff @(posedge Clk) begin
        if (!Reset_n || Flush) begin
            A <= '0;
            B <= '0;
            C <= '0;
        end else if (acc) begin
            C <= B;
            B <= A;
            A <= Din;
        end
    end

    // Output register captures the median of the window before any shift
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            Mid_out   <= '0;
            Mid_valid <= 1'b0;
        end else if (capture) begin
            Mid_out   <= Middle_in;
            Mid_valid <= 1'b1;
        end else if (Mid_valid && Mid_ready) begin
            Mid_valid <= 1'b0;
        end
    end

    // Count results taken by the downstream stage, wrapping naturally
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            Res_count <= '0;
        end else if (Mid_valid && Mid_ready) begin
            Res_count <= Res_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_median3_window_feeder.sv
// tb_median3_window_feeder
// Self-checking bench: directed table and sequences, an exhaustive triple
// sweep and a randomized run against a queue-based reference model. A small
// behavioural median stands in for the external middle_finder block.

module tb_median3_window_feeder;

    logic        clk;
    logic        reset_n;
    logic        flush;
    logic [3:0]  din;
    logic        din_valid;
    logic        din_ready;
    logic [3:0]  a;
    logic [3:0]  b;
    logic [3:0]  c;
    logic [3:0]  middle_in;
    logic [3:0]  mid_out;
    logic        mid_valid;
    logic        mid_ready;
    logic [15:0] res_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  din;
        logic        din_valid;
        logic        mid_ready;
        logic        exp_valid;
        logic [3:0]  exp_out;
        logic [15:0] exp_count;
    } vec_t;

    vec_t tbl[8];

    logic [3:0] hist[$];
    logic [3:0] expq[$];
    int         xfers;

    median3_window_feeder #(.WIDTH(4), .CNT_W(16)) dut (
        .Clk       (clk),
        .Reset_n   (reset_n),
        .Flush     (flush),
        .Din       (din),
        .Din_valid (din_valid),
        .Din_ready (din_ready),
        .A         (a),
        .B         (b),
        .C         (c),
        .Middle_in (middle_in),
        .Mid_out   (mid_out),
        .Mid_valid (mid_valid),
        .Mid_ready (mid_ready),
        .Res_count (res_count)
    );

    // Stand-in for middle_finder: sort three values and take the middle one
    function automatic logic [3:0] sort_mid(input logic [3:0] x, input logic [3:0] y, input logic [3:0] z);
        logic [3:0] v[3];
        logic [3:0] t;
        v[0] = x;
        v[1] = y;
        v[2] = z;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2 - i; j++) begin
                if (v[j] > v[j+1]) begin
                    t      = v[j];
                    v[j]   = v[j+1];
                    v[j+1] = t;
                end
            end
        end
        return v[1];
    endfunction

    // Reference median: total minus the extremes
    function automatic int ref_median(input int x, input int y, input int z);
        int mx;
        int mn;
        mx = (x > y) ? x : y;
        mx = (mx > z) ? mx : z;
        mn = (x < y) ? x : y;
        mn = (mn < z) ? mn : z;
        return x + y + z - mx - mn;
    endfunction

    assign middle_in = sort_mid(a, b, c);

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Drive inputs, take one rising edge, return at the following falling edge
    task automatic applyStimulus(input logic [3:0] d, input logic dv, input logic mr,
                                 input logic fl, input logic rn);
        din       = d;
        din_valid = dv;
        mid_ready = mr;
        flush     = fl;
        reset_n   = rn;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Main test sequence
    initial begin
        tbl[0] = '{4'd3, 1'b1, 1'b1, 1'b0, 4'd0, 16'd0};
        tbl[1] = '{4'd3, 1'b1, 1'b1, 1'b0, 4'd0, 16'd0};
        tbl[2] = '{4'd8, 1'b1, 1'b1, 1'b0, 4'd0, 16'd0};
        tbl[3] = '{4'd1, 1'b1, 1'b1, 1'b1, 4'd3, 16'd0};
        tbl[4] = '{4'd8, 1'b1, 1'b1, 1'b1, 4'd3, 16'd1};
        tbl[5] = '{4'd0, 1'b1, 1'b1, 1'b1, 4'd8, 16'd2};
        tbl[6] = '{4'd9, 1'b0, 1'b1, 1'b1, 4'd1, 16'd3};
        tbl[7] = '{4'd0, 1'b0, 1'b1, 1'b0, 4'd0, 16'd4};

        din = 4'd0; din_valid = 1'b0; mid_ready = 1'b0; flush = 1'b0; reset_n = 1'b0;

        // Reset while a sample is offered
        applyStimulus(4'd7, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(4'd7, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("rst_abc", {20'd0, a, b, c}, 32'd0);
        checkOutput("rst_mid_valid", mid_valid, 0);
        checkOutput("rst_mid_out", mid_out, 0);
        checkOutput("rst_res_count", res_count, 0);

        // Fill and latency: 5,9,2 then the result two edges after the third accept
        applyStimulus(4'd5, 1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("fill_valid_1", mid_valid, 0);
        applyStimulus(4'd9, 1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("fill_valid_2", mid_valid, 0);
        applyStimulus(4'd2, 1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("fill_valid_3", mid_valid, 0);
        checkOutput("fill_abc", {20'd0, a, b, c}, {20'd0, 4'd2, 4'd9, 4'd5});
        applyStimulus(4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("fill_lat_valid", mid_valid, 1);
        checkOutput("fill_lat_out", mid_out, 5);
        applyStimulus(4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("fill_drain_valid", mid_valid, 0);
        checkOutput("fill_res_count", res_count, 1);

        // Reset mid-operation clears everything
        applyStimulus(4'd7, 1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("rst2_abc", {20'd0, a, b, c}, 32'd0);
        checkOutput("rst2_out", {15'd0, mid_valid, mid_out, res_count}, 32'd0);

        // Table-driven stream 3,3,8,1,8,0
        for (int i = 0; i < 8; i++) begin
            applyStimulus(tbl[i].din, tbl[i].din_valid, tbl[i].mid_ready, 1'b0, 1'b1);
            checkOutput($sformatf("tbl_valid_%0d", i), mid_valid, tbl[i].exp_valid);
            if (tbl[i].exp_valid)
                checkOutput($sformatf("tbl_out_%0d", i), mid_out, tbl[i].exp_out);
            checkOutput($sformatf("tbl_count_%0d", i), res_count, tbl[i].exp_count);
        end

        // Backpressure: stalled result holds, input blocked, nothing lost
        applyStimulus(4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(4'd1, 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(4'd5, 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(4'd3, 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(4'd7, 1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("bp_first_out", {27'd0, mid_valid, mid_out}, {27'd0, 1'b1, 4'd3});
        checkOutput("bp_din_ready", din_ready, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'd9, 1'b1, 1'b0, 1'b0, 1'b1);
            checkOutput("bp_hold_out", {27'd0, mid_valid, mid_out}, {27'd0, 1'b1, 4'd3});
            checkOutput("bp_hold_a", a, 7);
            checkOutput("bp_hold_ready", din_ready, 0);
        end
        applyStimulus(4'd9, 1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("bp_rel_out", mid_out, 5);
        checkOutput("bp_rel_a", a, 9);
        checkOutput("bp_rel_count", res_count, 1);
        applyStimulus(4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("bp_next_out", {27'd0, mid_valid, mid_out}, {27'd0, 1'b1, 4'd7});
        applyStimulus(4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("bp_end", {15'd0, mid_valid, res_count}, 32'd3);

        // Flush drops the concurrent sample and restarts filling
        applyStimulus(4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(4'd4, 1'b1, 1'b1, 1'b0, 1'b1);
        applyStimulus(4'd6, 1'b1, 1'b1, 1'b0, 1'b1);
        applyStimulus(4'd8, 1'b1, 1'b1, 1'b1, 1'b1);
        checkOutput("flush_abc", {20'd0, a, b, c}, 32'd0);
        applyStimulus(4'd1, 1'b1, 1'b1, 1'b0, 1'b1);
        applyStimulus(4'd2, 1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("flush_refill_valid", mid_valid, 0);
        applyStimulus(4'd3, 1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("flush_fill_valid", mid_valid, 0);
        applyStimulus(4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("flush_result", {27'd0, mid_valid, mid_out}, {27'd0, 1'b1, 4'd2});

        // Exhaustive triples, each in a fresh window separated by a flush
        applyStimulus(4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                for (int z = 0; z < 16; z++) begin
                    applyStimulus(4'(x), 1'b1, 1'b1, 1'b0, 1'b1);
                    applyStimulus(4'(y), 1'b1, 1'b1, 1'b0, 1'b1);
                    applyStimulus(4'(z), 1'b1, 1'b1, 1'b0, 1'b1);
                    applyStimulus(4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
                    checkOutput($sformatf("exh_%0d_%0d_%0d", x, y, z),
                                {27'd0, mid_valid, mid_out},
                                {27'd0, 1'b1, 4'(ref_median(x, y, z))});
                    applyStimulus(4'd0, 1'b0, 1'b1, 1'b1, 1'b1);
                end
            end
        end
        checkOutput("exh_res_count", res_count, 4096);

        // Randomized traffic against the queue model
        applyStimulus(4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        xfers = 0;
        hist.delete();
        expq.delete();
        for (int n = 0; n < 3000; n++) begin
            din       = 4'($urandom_range(0, 15));
            din_valid = ($urandom_range(0, 9) < 7);
            mid_ready = ($urandom_range(0, 9) < 6);
            flush     = 1'b0;
            reset_n   = 1'b1;
            #1;
            if (mid_valid && mid_ready) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL rand_extra_result actual=%0d expected=none", mid_out);
                end else begin
                    checkOutput("rand_mid_out", mid_out, expq.pop_front());
                end
                xfers++;
            end
            if (din_valid && din_ready) begin
                hist.push_back(din);
                if (hist.size() > 3) void'(hist.pop_front());
                if (hist.size() == 3)
                    expq.push_back(4'(ref_median(hist[0], hist[1], hist[2])));
            end
            @(posedge clk);
            @(negedge clk);
        end
        din_valid = 1'b0;
        mid_ready = 1'b1;
        for (int n = 0; n < 20 && (expq.size() != 0 || mid_valid); n++) begin
            #1;
            if (mid_valid) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL rand_extra_result actual=%0d expected=none", mid_out);
                end else begin
                    checkOutput("rand_drain_out", mid_out, expq.pop_front());
                end
                xfers++;
            end
            @(posedge clk);
            @(negedge clk);
        end
        checkOutput("rand_left_over", expq.size(), 0);
        checkOutput("rand_res_count", res_count, 32'(xfers[15:0]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
